bird_physics: RTL and testbench

// Game-state and vertical-motion engine for the bird. Sits directly downstream of
// the clock divider: samples its 50 Hz clk_game output as data in the 100 MHz

---
 rtl/bird_physics.sv | 200 ++++++++++++++++++++
 tb/tb_bird_physics.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_physics.sv
// ----------------------------------------------------------------------------
// bird_physics
// Game-state and vertical-motion engine for the bird. The 50 Hz clk_game from
// the divider is sampled as data in the clock_in domain. Each rising edge
// becomes a one-cycle physics tick. On each tick, gravity and flap impulses are
// integrated into bird_y/bird_vel, and the IDLE/FLYING/DEAD game state advances.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | bird parked at Y_START, waits for a flap to start flying
//   FLYING  | gravity/flap integration, ceiling clamp, floor and hit kill
//   DEAD    | position frozen, game_over high, a flap returns to IDLE
//   (11)    | unreachable; the next tick forces IDLE
//
// Ports:
//   clock_in   in   1   100 MHz master clock
//   rst        in   1   asynchronous, active-high reset
//   clk_game   in   1   divided game clock, sampled as data only
//   flap       in   1   asynchronous button level, rising edge = flap request
//   hit        in   1   collision flag, only looked at on ticks
//   bird_y     out  10  bird top y (0 = top of screen), unsigned
//   bird_vel   out  8   signed velocity in px/tick, negative = up
//   state      out  2   00 IDLE, 01 FLYING, 10 DEAD
//   game_over  out  1   high whenever state is DEAD
//   frame_tick out  1   one-cycle pulse, high the cycle the outputs update
// ----------------------------------------------------------------------------
module bird_physics #(
    parameter int Y_START = 240,
    parameter int CEIL_Y  = 0,
    parameter int FLOOR_Y = 460,
    parameter int GRAVITY = 1,
    parameter int FLAP_V  = 8,
    parameter int VMAX    = 10
) (
    input  logic              clock_in,
    input  logic              rst,
    input  logic              clk_game,
    input  logic              flap,
    input  logic              hit,
    output logic [9:0]        bird_y,
    output logic signed [7:0] bird_vel,
    output logic [1:0]        state,
    output logic              game_over,
    output logic              frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FLYING = 2'b01,
        ST_DEAD   = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    localparam logic signed [7:0]  GRAV8     = 8'(GRAVITY);
    localparam logic signed [7:0]  VMAX8     = 8'(VMAX);
    localparam logic signed [7:0]  FLAP_NEG8 = 8'(-FLAP_V);
    localparam logic signed [11:0] CEIL12    = 12'(CEIL_Y);
    localparam logic signed [11:0] FLOOR12   = 12'(FLOOR_Y);
    localparam logic [9:0]         Y_START10 = 10'(Y_START);
    localparam logic [9:0]         Y_FLAP10  = 10'(Y_START - FLAP_V);
    localparam logic [9:0]         CEIL10    = 10'(CEIL_Y);
    localparam logic [9:0]         FLOOR10   = 10'(FLOOR_Y);

    state_t state_r;

    // clk_game synchronizer and edge register
    logic cg_meta;
    logic cg_sync;
    logic cg_prev;

    // flap synchronizer and edge register
    logic       fl_meta;
    logic       fl_sync;
    logic       fl_prev;
    logic [1:0] fl_prime;
    logic       fl_armed;

    logic flap_pending;
    logic tick;
    logic flap_edge;
    logic flap_req;

    logic signed [7:0]  vel_grav;
    logic signed [7:0]  vel_n;
    logic signed [11:0] y_n;

    assign state = state_r;

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            cg_meta  <= 1'b0;
            cg_sync  <= 1'b0;
            cg_prev  <= 1'b0;
            fl_meta  <= 1'b0;
            fl_sync  <= 1'b0;
            fl_prev  <= 1'b0;
            fl_prime <= 2'b00;
            fl_armed <= 1'b0;
        end else begin
            cg_meta  <= clk_game;
            cg_sync  <= cg_meta;
            cg_prev  <= cg_sync;
            fl_meta  <= flap;
            fl_sync  <= fl_meta;
            fl_prev  <= fl_sync;
            // fl_sync carries real button data only once fl_prime[1] is set.
            // The button must then be seen released before any rising edge
            // counts. This stops a button held through reset from reading as
            // a flap.
            fl_prime <= {fl_prime[0], 1'b1};
            if (fl_prime[1] && !fl_sync) begin
                fl_armed <= 1'b1;
            end
        end
    end

    assign tick      = cg_sync & ~cg_prev;
    assign flap_edge = fl_sync & ~fl_prev & fl_armed;
    // An edge that lands on the tick cycle is consumed by that tick.
    assign flap_req  = flap_pending | flap_edge;

    always_comb begin
        vel_grav = bird_vel + GRAV8;
        if (vel_grav > VMAX8) begin
            vel_grav = VMAX8;
        end
        vel_n = flap_req ? FLAP_NEG8 : vel_grav;
        // 12-bit signed so that overshoot above the ceiling stays negative.
        y_n = $signed({2'b00, bird_y}) + {{4{vel_n[7]}}, vel_n};
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bird_y       <= Y_START10;
            bird_vel     <= '0;
            game_over    <= 1'b0;
            frame_tick   <= 1'b0;
            flap_pending <= 1'b0;
        end else begin
            frame_tick <= tick;

            if (tick) begin
                flap_pending <= 1'b0;
            end else if (flap_edge) begin
                flap_pending <= 1'b1;
            end

            if (tick) begin
                case (state_r)
                    ST_IDLE: begin
                        game_over <= 1'b0;
                        if (flap_req) begin
                            state_r  <= ST_FLYING;
                            bird_y   <= Y_FLAP10;
                            bird_vel <= FLAP_NEG8;
                        end else begin
                            bird_y   <= Y_START10;
                            bird_vel <= '0;
                        end
                    end
                    ST_FLYING: begin
                        if (hit) begin
                            state_r   <= ST_DEAD;
                            bird_vel  <= '0;
                            game_over <= 1'b1;
                        end else if (y_n <= CEIL12) begin
                            bird_y   <= CEIL10;
                            bird_vel <= '0;
                        end else if (y_n >= FLOOR12) begin
                            state_r   <= ST_DEAD;
                            bird_y    <= FLOOR10;
                            bird_vel  <= '0;
                            game_over <= 1'b1;
                        end else begin
                            bird_y   <= y_n[9:0];
                            bird_vel <= vel_n;
                        end
                    end
                    ST_DEAD: begin
                        if (flap_req) begin
                            state_r   <= ST_IDLE;
                            bird_y    <= Y_START10;
                            bird_vel  <= '0;
                            game_over <= 1'b0;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        bird_y    <= Y_START10;
                        bird_vel  <= '0;
                        game_over <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bird_physics.sv
module tb_bird_physics;

    logic              clock_in = 1'b0;
    logic              rst      = 1'b1;
    logic              clk_game = 1'b0;
    logic              flap     = 1'b0;
    logic              hit      = 1'b0;
    logic [9:0]        bird_y;
    logic signed [7:0] bird_vel;
    logic [1:0]        state;
    logic              game_over;
    logic              frame_tick;

    int total = 0;
    int bad   = 0;

    bird_physics dut (
        .clock_in   (clock_in),
        .rst        (rst),
        .clk_game   (clk_game),
        .flap       (flap),
        .hit        (hit),
        .bird_y     (bird_y),
        .bird_vel   (bird_vel),
        .state      (state),
        .game_over  (game_over),
        .frame_tick (frame_tick)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Raise clk_game and wait (bounded) for frame_tick, then drop clk_game.
    task automatic game_tick();
        bit got;
        got = 1'b0;
        clk_game = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_in);
            #1;
            if (frame_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL tick_timeout: frame_tick=0 after 10 cycles, want 1");
        end
        clk_game = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
    endtask

    task automatic pulse_flap();
        flap = 1'b1;
        repeat (3) @(posedge clock_in);
        #1;
        flap = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clock_in);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clock_in);
        #1;
        total++;
        if (bird_y !== 10'd240 || bird_vel !== 8'sd0 || state !== 2'b00 ||
            game_over !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: y=%0d vel=%0d st=%b go=%b ft=%b, want 240 0 00 0 0",
                     bird_y, bird_vel, state, game_over, frame_tick);
        end
        game_tick();
        game_tick();
        total++;
        if (bird_y !== 10'd240 || bird_vel !== 8'sd0 || state !== 2'b00 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_flap: y=%0d vel=%0d st=%b go=%b, want 240 0 00 0",
                     bird_y, bird_vel, state, game_over);
        end
    endtask

    task automatic test_flight();
        logic [9:0]        ey [18];
        logic signed [7:0] ev [18];
        ey = '{10'd225, 10'd219, 10'd214, 10'd210, 10'd207, 10'd205, 10'd204, 10'd204, 10'd205,
               10'd207, 10'd210, 10'd214, 10'd219, 10'd225, 10'd232, 10'd240, 10'd249, 10'd259};
        ev = '{-8'sd7, -8'sd6, -8'sd5, -8'sd4, -8'sd3, -8'sd2, -8'sd1, 8'sd0, 8'sd1,
               8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9, 8'sd10};
        pulse_flap();
        game_tick();
        total++;
        if (bird_y !== 10'd232 || bird_vel !== -8'sd8 || state !== 2'b01 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL first_flap: y=%0d vel=%0d st=%b ft=%b, want 232 -8 01 0",
                     bird_y, bird_vel, state, frame_tick);
        end
        for (int i = 0; i < 18; i++) begin
            game_tick();
            total++;
            if (bird_y !== ey[i] || bird_vel !== ev[i] || state !== 2'b01) begin
                bad++;
                $display("FAIL fall_step%0d: y=%0d vel=%0d st=%b, want %0d %0d 01",
                         i, bird_y, bird_vel, state, ey[i], ev[i]);
            end
        end
        game_tick();
        total++;
        if (bird_y !== 10'd269 || bird_vel !== 8'sd10) begin
            bad++;
            $display("FAIL terminal_vel: y=%0d vel=%0d, want 269 10", bird_y, bird_vel);
        end
    endtask

    task automatic test_floor();
        logic [9:0] want_y;
        for (int c = 0; c < 4; c++) begin
            pulse_flap();
            game_tick();
            repeat (18) game_tick();
            want_y = 10'(288 + 19 * c);
            total++;
            if (bird_y !== want_y || bird_vel !== 8'sd10 || state !== 2'b01) begin
                bad++;
                $display("FAIL flap_cycle%0d: y=%0d vel=%0d st=%b, want %0d 10 01",
                         c, bird_y, bird_vel, state, want_y);
            end
        end
        repeat (11) game_tick();
        total++;
        if (bird_y !== 10'd455 || bird_vel !== 8'sd10 || state !== 2'b01) begin
            bad++;
            $display("FAIL near_floor: y=%0d vel=%0d st=%b, want 455 10 01", bird_y, bird_vel, state);
        end
        game_tick();
        total++;
        if (bird_y !== 10'd460 || bird_vel !== 8'sd0 || state !== 2'b10 || game_over !== 1'b1) begin
            bad++;
            $display("FAIL floor_death: y=%0d vel=%0d st=%b go=%b, want 460 0 10 1",
                     bird_y, bird_vel, state, game_over);
        end
        hit = 1'b1;
        game_tick();
        hit = 1'b0;
        total++;
        if (bird_y !== 10'd460 || bird_vel !== 8'sd0 || state !== 2'b10 || game_over !== 1'b1) begin
            bad++;
            $display("FAIL dead_hold: y=%0d vel=%0d st=%b go=%b, want 460 0 10 1",
                     bird_y, bird_vel, state, game_over);
        end
        pulse_flap();
        game_tick();
        total++;
        if (bird_y !== 10'd240 || bird_vel !== 8'sd0 || state !== 2'b00 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL dead_restart: y=%0d vel=%0d st=%b go=%b, want 240 0 00 0",
                     bird_y, bird_vel, state, game_over);
        end
    endtask

    task automatic test_ceiling();
        pulse_flap();
        game_tick();
        game_tick();
        total++;
        if (bird_y !== 10'd225 || bird_vel !== -8'sd7) begin
            bad++;
            $display("FAIL climb_start: y=%0d vel=%0d, want 225 -7", bird_y, bird_vel);
        end
        repeat (24) begin
            pulse_flap();
            game_tick();
        end
        total++;
        if (bird_y !== 10'd33 || bird_vel !== -8'sd8) begin
            bad++;
            $display("FAIL climb_flaps: y=%0d vel=%0d, want 33 -8", bird_y, bird_vel);
        end
        repeat (8) game_tick();
        total++;
        if (bird_y !== 10'd5 || bird_vel !== 8'sd0 || state !== 2'b01) begin
            bad++;
            $display("FAIL apex: y=%0d vel=%0d st=%b, want 5 0 01", bird_y, bird_vel, state);
        end
        pulse_flap();
        pulse_flap();
        pulse_flap();
        game_tick();
        total++;
        if (bird_y !== 10'd0 || bird_vel !== 8'sd0 || state !== 2'b01) begin
            bad++;
            $display("FAIL ceiling_clamp: y=%0d vel=%0d st=%b, want 0 0 01", bird_y, bird_vel, state);
        end
        game_tick();
        total++;
        if (bird_y !== 10'd1 || bird_vel !== 8'sd1 || state !== 2'b01) begin
            bad++;
            $display("FAIL flaps_collapsed: y=%0d vel=%0d st=%b, want 1 1 01", bird_y, bird_vel, state);
        end
    endtask

    task automatic test_hit();
        pulse_flap();
        hit = 1'b1;
        game_tick();
        hit = 1'b0;
        total++;
        if (bird_y !== 10'd1 || bird_vel !== 8'sd0 || state !== 2'b10 || game_over !== 1'b1) begin
            bad++;
            $display("FAIL hit_death: y=%0d vel=%0d st=%b go=%b, want 1 0 10 1",
                     bird_y, bird_vel, state, game_over);
        end
        pulse_flap();
        game_tick();
        total++;
        if (bird_y !== 10'd240 || state !== 2'b00 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL hit_restart: y=%0d st=%b go=%b, want 240 00 0", bird_y, state, game_over);
        end
    endtask

    task automatic test_reset_midflight();
        pulse_flap();
        game_tick();
        game_tick();
        total++;
        if (bird_y !== 10'd225 || bird_vel !== -8'sd7 || state !== 2'b01) begin
            bad++;
            $display("FAIL preflight: y=%0d vel=%0d st=%b, want 225 -7 01", bird_y, bird_vel, state);
        end
        @(negedge clock_in);
        flap = 1'b1;
        rst  = 1'b1;
        #1;
        total++;
        if (bird_y !== 10'd240 || bird_vel !== 8'sd0 || state !== 2'b00 ||
            game_over !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: y=%0d vel=%0d st=%b go=%b ft=%b, want 240 0 00 0 0",
                     bird_y, bird_vel, state, game_over, frame_tick);
        end
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        rst = 1'b0;
        repeat (6) @(posedge clock_in);
        #1;
        game_tick();
        total++;
        if (state !== 2'b00 || bird_y !== 10'd240) begin
            bad++;
            $display("FAIL held_flap: st=%b y=%0d, want 00 240", state, bird_y);
        end
        flap = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        pulse_flap();
        game_tick();
        total++;
        if (bird_y !== 10'd232 || bird_vel !== -8'sd8 || state !== 2'b01) begin
            bad++;
            $display("FAIL post_reset_flap: y=%0d vel=%0d st=%b, want 232 -8 01", bird_y, bird_vel, state);
        end
    endtask

    initial begin
        test_reset();
        test_flight();
        test_floor();
        test_ceiling();
        test_hit();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
